// File: rtl/prbs7_checker.sv
// Self-synchronising PRBS7 (x^7 + x^6 + 1) checker: hunts for lock on the
// received stream, then flags bit errors and accumulates BER counts.
module prbs7_checker #(
  parameter int LOCK_COUNT  = 16,
  parameter int WINDOW      = 64,
  parameter int UNLOCK_ERRS = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        din,
  input  logic        din_valid,
  input  logic        clear_counts,
  output logic        locked,
  output logic        err_pulse,
  output logic [15:0] err_count,
  output logic [31:0] bit_count
);

  localparam logic [1:0] FILL = 2'd0;
  localparam logic [1:0] HUNT = 2'd1;
  localparam logic [1:0] LOCK = 2'd2;

  localparam logic [7:0]  LOCK_TGT   = 8'(LOCK_COUNT);
  localparam logic [15:0] WIN_LAST   = 16'(WINDOW - 1);
  localparam logic [15:0] UNLOCK_TGT = 16'(UNLOCK_ERRS);

  logic [1:0]  state;
  logic [6:0]  sh;
  logic [2:0]  fill_cnt;
  logic [7:0]  match_cnt;
  logic [15:0] win_bits;
  logic [15:0] win_errs;
  logic        pred;
  logic        err;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (&v) ? v : v + 16'd1;
  endfunction

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction

  assign pred = sh[6] ^ sh[5];
  assign err  = din ^ pred;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= FILL;
      sh        <= '0;
      fill_cnt  <= '0;
      match_cnt <= '0;
      win_bits  <= '0;
      win_errs  <= '0;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
      err_count <= '0;
      bit_count <= '0;
    end else begin
      err_pulse <= 1'b0;
      if (din_valid) begin
        case (state)
          FILL: begin
            sh <= {sh[5:0], din};
            if (fill_cnt == 3'd6) begin
              state     <= HUNT;
              fill_cnt  <= '0;
              match_cnt <= '0;
            end else begin
              fill_cnt <= fill_cnt + 3'd1;
            end
          end
          HUNT: begin
            sh <= {sh[5:0], din};
            // An all-zero history plus a zero bit is the LFSR lock-up state, never a match
            if (!err && ({sh, din} != 8'd0)) begin
              if (match_cnt + 8'd1 == LOCK_TGT) begin
                state     <= LOCK;
                locked    <= 1'b1;
                match_cnt <= '0;
                win_bits  <= '0;
                win_errs  <= '0;
              end else begin
                match_cnt <= match_cnt + 8'd1;
              end
            end else begin
              match_cnt <= '0;
            end
          end
          LOCK: begin
            // Regenerate locally so one line error yields one flagged error
            sh        <= {sh[5:0], pred};
            err_pulse <= err;
            if (err && (win_errs + 16'd1 == UNLOCK_TGT)) begin
              state     <= FILL;
              locked    <= 1'b0;
              sh        <= '0;
              fill_cnt  <= '0;
              match_cnt <= '0;
              win_bits  <= '0;
              win_errs  <= '0;
            end else if (win_bits == WIN_LAST) begin
              win_bits <= '0;
              win_errs <= '0;
            end else begin
              win_bits <= win_bits + 16'd1;
              win_errs <= win_errs + {15'd0, err};
            end
          end
          default: begin
            state  <= FILL;
            locked <= 1'b0;
          end
        endcase
      end

      if (clear_counts) begin
        err_count <= '0;
        bit_count <= '0;
      end else if (din_valid && (state == LOCK)) begin
        bit_count <= sat_inc32(bit_count);
        if (err) err_count <= sat_inc16(err_count);
      end
    end
  end

endmodule

// File: doc/prbs7_checker.md
# prbs7_checker

Self-synchronising PRBS7 checker that consumes the serial bit stream produced by the 7-bit LFSR stage (`q` qualified by `valid_out`) at the receive side of the comm stack.
- Locks onto the sequence d[n] = d[n-7] XOR d[n-6] without needing the seed.
- Reports lock status and flags each bit error.
- Accumulates bit and error counts for link BER measurement.

## Interface
- LOCK_COUNT, 16: consecutive correct predictions in HUNT required to declare lock (1..255)
- WINDOW, 64: length in valid bits of the loss-of-lock observation window (2..65535)
- UNLOCK_ERRS, 8: errors within one window that force loss of lock (1..WINDOW)
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state and outputs
- din  in  1  received serial bit
- din_valid  in  1  din is sampled only on cycles where this is high
- clear_counts  in  1  synchronous clear of err_count and bit_count
- locked  out  1  checker is in LOCKED
- err_pulse  out  1  one-cycle pulse per detected bit error (LOCKED only)
- err_count  out  16  saturating error count
- bit_count  out  32  saturating count of bits checked while LOCKED

## Operation
- 7-bit history register `sh`; sh[0] holds the newest bit.
  - Predicted bit p = sh[6] ^ sh[5].
- State FILL:
  - Shift din into sh on each valid bit.
  - After 7 valid bits, go to HUNT; match counter = 0.
- State HUNT, per valid bit:
  - Compare din with p, then shift din into sh.
  - din == p and {sh,din} not all-zero: increment match counter.
  - Otherwise: match counter = 0. An all-zero pattern is never a match, so constant 0 cannot lock.
  - When match counter reaches LOCK_COUNT, go to LOCKED; window counters = 0.
- State LOCKED, per valid bit:
  - Shift p (not din) into sh, so a single error does not multiply.
  - bit_count += 1.
  - din != p: err_pulse = 1, err_count += 1, window error count += 1.
  - Window bit count runs 0..WINDOW-1. The bit that completes a window is counted in that window first; both window counters then clear.
  - Window error count reaching UNLOCK_ERRS: go to FILL on that same bit, discarding history; match counter = 0.
- Counters saturate at all-ones and never wrap.
- clear_counts zeroes both counters. If it coincides with an error or a counted bit, the clear wins and the result is 0.
- Cycles with din_valid low: no state, history or counter change. err_pulse is 0 and clear_counts still acts.

## Timing
- All outputs are registered.
- Reset values: locked = 0, err_pulse = 0, err_count = 0, bit_count = 0. State = FILL, history and all internal counters = 0.
- Reset asserted mid-operation forces these values immediately (asynchronous). The first valid bit after deassertion is FILL bit 1.
- locked rises in the cycle after the edge that samples the LOCK_COUNT-th HUNT match.
  - Clean continuous stream: locked first high after 7 + LOCK_COUNT valid bits.
- err_pulse, err_count and bit_count update in the cycle after the sampling edge; latency is 1.
- locked falls in the cycle after the edge that samples the UNLOCK_ERRS-th window error. That bit still counts as an error.
- Throughput: one bit per clock. din_valid may be low for any number of cycles without affecting results.

## Test plan
- Reset:
  - Assert reset for 2 cycles with din toggling.
  - Required: all outputs 0; no lock after release until 23 clean bits.
- Clean lock:
  - Feed an LFSR stream seeded 7'b1010101 with continuous valid.
  - Required: locked high after valid bit 23, err_count stays 0, bit_count = N−23 after N bits.
- Single error:
  - While locked, invert one bit.
  - Required: one err_pulse, err_count = 1, locked stays 1, no further errors.
- Loss of lock and relock:
  - Invert 8 bits within one 64-bit window.
  - Required: err_count = 8; locked falls after the 8th error and rises again 23 clean bits later.
  - Also: 7 errors per window in each of two consecutive windows keeps locked = 1.
- Degenerate input:
  - Feed constant 0 for 200 bits.
  - Required: locked never asserts.
  - Then feed constant 1 for 200 bits: must also never lock.
- Gaps, clear and mid-run reset:
  - din_valid high every 3rd cycle: lock after the 23rd valid bit.
  - clear_counts together with an error bit: err_count = 0 next cycle.
  - Reset while locked: locked = 0 without waiting for a clock edge.
